// File: rtl/hazard_fwd_unit_pkg.sv
// Shared constants for the forwarding / hazard unit.
// Source index FWD_SRC_MEM is the youngest write-back source (EX/MEM); higher
// indices are progressively older stages.
package hazard_fwd_unit_pkg;

   localparam int FWD_SRC_MEM   = 0;
   localparam int CSR_ADDR_W    = 12;
   localparam int REG_ZERO_ADDR = 0;
   localparam int STALL_CNT_W   = 32;
   localparam int LD_CNT_W      = 3;

   localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Forwarding bus between the pipeline and the hazard unit: write-back sources,
// regfile read ports and the bypassed operands coming back.
interface hazard_fwd_unit_if #(
   parameter int XLEN    = 32,
   parameter int RA_W    = 5,
   parameter int NUM_RD  = 2,
   parameter int NUM_SRC = 2
);

   logic [NUM_SRC-1:0]      fwd_req_i;
   logic [NUM_SRC*RA_W-1:0] fwd_addr_i;
   logic [NUM_SRC*XLEN-1:0] fwd_data_i;
   logic [NUM_RD-1:0]       rd_use_i;
   logic [NUM_RD*RA_W-1:0]  rd_addr_i;
   logic [NUM_RD*XLEN-1:0]  rd_data_i;
   logic [NUM_RD*XLEN-1:0]  rd_data_o;

   modport master (
      output fwd_req_i, fwd_addr_i, fwd_data_i, rd_use_i, rd_addr_i, rd_data_i,
      input  rd_data_o
   );

   modport slave (
      input  fwd_req_i, fwd_addr_i, fwd_data_i, rd_use_i, rd_addr_i, rd_data_i,
      output rd_data_o
   );

endinterface

// File: rtl/hazard_fwd_unit_fwd_mux.sv
// One read port's bypass selector: picks the youngest write-back source whose
// destination matches the read address, otherwise the regfile value.
// Register x0 is never bypassed.
module hazard_fwd_unit_fwd_mux
   import hazard_fwd_unit_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int RA_W    = 5,
   parameter int NUM_SRC = 2
) (
   input  logic [NUM_SRC-1:0]      fwd_req_i,
   input  logic [NUM_SRC*RA_W-1:0] fwd_addr_i,
   input  logic [NUM_SRC*XLEN-1:0] fwd_data_i,
   input  logic [RA_W-1:0]         rd_addr_i,
   input  logic [XLEN-1:0]         rd_data_i,
   output logic [XLEN-1:0]         rd_data_o
);

   // Walk from oldest to youngest so the youngest matching source overrides.
   always_comb begin
      rd_data_o = rd_data_i;
      if (rd_addr_i != RA_W'(REG_ZERO_ADDR)) begin
         for (int s = NUM_SRC - 1; s >= FWD_SRC_MEM; s--) begin
            if (fwd_req_i[s] && (fwd_addr_i[s*RA_W +: RA_W] == rd_addr_i)) begin
               rd_data_o = fwd_data_i[s*XLEN +: XLEN];
            end
         end
      end
   end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Forwarding and hazard unit: per-port priority bypass, registered load
// scoreboard (busy bitmap + outstanding-load count) driving load-use / WAW /
// full stalls, a saturating stall-cycle counter and an optional CSR bypass.
// Optional feature macro: FWD_CSR_EN enables CSR write-to-read bypass.
module hazard_fwd_unit
   import hazard_fwd_unit_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int RA_W    = 5,
   parameter int NUM_RD  = 2,
   parameter int NUM_SRC = 2,
   parameter int MAX_LD  = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush_i,
   hazard_fwd_unit_if.slave       bus,
   input  logic                   ld_issue_i,
   input  logic [RA_W-1:0]        ld_rd_i,
   input  logic                   ld_done_i,
   input  logic [RA_W-1:0]        ld_done_rd_i,
   output logic                   stall_o,
   output logic                   ld_full_o,
   output logic [STALL_CNT_W-1:0] stall_cnt_o,
   input  logic                   w_csr_req_i,
   input  logic [CSR_ADDR_W-1:0]  w_csr_addr_i,
   input  logic [XLEN-1:0]        w_csr_data_i,
   input  logic [CSR_ADDR_W-1:0]  r_csr_addr_i,
   input  logic [XLEN-1:0]        r_csr_data_i,
   output logic [XLEN-1:0]        r_csr_data_o
);

   localparam int NREG = 2 ** RA_W;

   logic [NREG-1:0]        busy_q, busy_d;
   logic [LD_CNT_W-1:0]    ld_cnt_q, ld_cnt_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [NUM_RD-1:0]      use_hazard;
   logic                   waw_hazard;
   logic                   done_ok;
   logic                   issue_ok;

   for (genvar p = 0; p < NUM_RD; p++) begin : g_port
      hazard_fwd_unit_fwd_mux #(
         .XLEN    (XLEN),
         .RA_W    (RA_W),
         .NUM_SRC (NUM_SRC)
      ) u_fwd_mux (
         .fwd_req_i  (bus.fwd_req_i),
         .fwd_addr_i (bus.fwd_addr_i),
         .fwd_data_i (bus.fwd_data_i),
         .rd_addr_i  (bus.rd_addr_i[p*RA_W +: RA_W]),
         .rd_data_i  (bus.rd_data_i[p*XLEN +: XLEN]),
         .rd_data_o  (bus.rd_data_o[p*XLEN +: XLEN])
      );
   end

   assign ld_full_o = (ld_cnt_q == LD_CNT_W'(MAX_LD));

   // Hazard detection: a busy source or destination only stalls when its load is not returning right now.
   always_comb begin
      for (int p = 0; p < NUM_RD; p++) begin
         use_hazard[p] = bus.rd_use_i[p]
                      && (bus.rd_addr_i[p*RA_W +: RA_W] != RA_W'(REG_ZERO_ADDR))
                      && busy_q[bus.rd_addr_i[p*RA_W +: RA_W]]
                      && !(ld_done_i && (ld_done_rd_i == bus.rd_addr_i[p*RA_W +: RA_W]));
      end
      waw_hazard = ld_issue_i
                && (ld_rd_i != RA_W'(REG_ZERO_ADDR))
                && busy_q[ld_rd_i]
                && !(ld_done_i && (ld_done_rd_i == ld_rd_i));
      stall_o    = (|use_hazard) || waw_hazard || (ld_issue_i && ld_full_o);
      done_ok    = ld_done_i && (ld_cnt_q != '0);
      issue_ok   = ld_issue_i && !waw_hazard && (!ld_full_o || done_ok);
   end

   // Scoreboard next state: completion clears first so a same-register issue keeps the bit set.
   always_comb begin
      busy_d   = busy_q;
      ld_cnt_d = ld_cnt_q + {{(LD_CNT_W-1){1'b0}}, issue_ok} - {{(LD_CNT_W-1){1'b0}}, done_ok};
      if (done_ok) begin
         busy_d[ld_done_rd_i] = 1'b0;
      end
      if (issue_ok && (ld_rd_i != RA_W'(REG_ZERO_ADDR))) begin
         busy_d[ld_rd_i] = 1'b1;
      end
      busy_d[REG_ZERO_ADDR] = 1'b0;
      if (flush_i) begin
         busy_d   = '0;
         ld_cnt_d = '0;
      end
   end

   // Stall counter saturates rather than wrapping; flush does not touch it.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_o && (stall_cnt_q != STALL_CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q      <= '0;
         ld_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         busy_q      <= busy_d;
         ld_cnt_q    <= ld_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;

`ifdef FWD_CSR_EN
   // A CSR write in flight this cycle supersedes the CSR file's stale read value.
   always_comb begin
      r_csr_data_o = r_csr_data_i;
      if (w_csr_req_i && (w_csr_addr_i == r_csr_addr_i)) begin
         r_csr_data_o = w_csr_data_i;
      end
   end
`else
   logic unused_csr;
   assign unused_csr   = ^{w_csr_req_i, w_csr_addr_i, w_csr_data_i, r_csr_addr_i};
   assign r_csr_data_o = r_csr_data_i;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: directed scenarios followed by random traffic,
// all checked against a scoreboard model built from the unit's stated rules.
module tb_hazard_fwd_unit;

   localparam int XLEN    = 32;
   localparam int RA_W    = 5;
   localparam int NUM_RD  = 2;
   localparam int NUM_SRC = 2;
   localparam int MAX_LD  = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              flush_i;
   logic              ld_issue_i;
   logic [RA_W-1:0]   ld_rd_i;
   logic              ld_done_i;
   logic [RA_W-1:0]   ld_done_rd_i;
   logic              stall_o;
   logic              ld_full_o;
   logic [31:0]       stall_cnt_o;
   logic              w_csr_req_i;
   logic [11:0]       w_csr_addr_i;
   logic [XLEN-1:0]   w_csr_data_i;
   logic [11:0]       r_csr_addr_i;
   logic [XLEN-1:0]   r_csr_data_i;
   logic [XLEN-1:0]   r_csr_data_o;

   // Reference model state
   bit          mBusy [32];
   int          mCnt;
   logic [31:0] mScnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_fwd_unit_if #(.XLEN(XLEN), .RA_W(RA_W), .NUM_RD(NUM_RD), .NUM_SRC(NUM_SRC)) bus ();

   hazard_fwd_unit #(
      .XLEN(XLEN), .RA_W(RA_W), .NUM_RD(NUM_RD), .NUM_SRC(NUM_SRC), .MAX_LD(MAX_LD)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush_i      (flush_i),
      .bus          (bus),
      .ld_issue_i   (ld_issue_i),
      .ld_rd_i      (ld_rd_i),
      .ld_done_i    (ld_done_i),
      .ld_done_rd_i (ld_done_rd_i),
      .stall_o      (stall_o),
      .ld_full_o    (ld_full_o),
      .stall_cnt_o  (stall_cnt_o),
      .w_csr_req_i  (w_csr_req_i),
      .w_csr_addr_i (w_csr_addr_i),
      .w_csr_data_i (w_csr_data_i),
      .r_csr_addr_i (r_csr_addr_i),
      .r_csr_data_i (r_csr_data_i),
      .r_csr_data_o (r_csr_data_o)
   );

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Youngest requesting source with a matching nonzero address wins.
   function automatic logic [XLEN-1:0] expOperand(input int p);
      logic [RA_W-1:0] ra;
      ra = bus.rd_addr_i[p*RA_W +: RA_W];
      if (ra == 0) return bus.rd_data_i[p*XLEN +: XLEN];
      for (int s = 0; s < NUM_SRC; s++) begin
         if (bus.fwd_req_i[s] && bus.fwd_addr_i[s*RA_W +: RA_W] == ra)
            return bus.fwd_data_i[s*XLEN +: XLEN];
      end
      return bus.rd_data_i[p*XLEN +: XLEN];
   endfunction

   function automatic bit returning(input logic [RA_W-1:0] a);
      return ld_done_i && (ld_done_rd_i == a);
   endfunction

   function automatic bit expWaw();
      return ld_issue_i && ld_rd_i != 0 && mBusy[ld_rd_i] && !returning(ld_rd_i);
   endfunction

   function automatic bit expStall();
      bit st;
      st = expWaw() || (ld_issue_i && mCnt == MAX_LD);
      for (int p = 0; p < NUM_RD; p++) begin
         if (bus.rd_use_i[p] && bus.rd_addr_i[p*RA_W +: RA_W] != 0
             && mBusy[bus.rd_addr_i[p*RA_W +: RA_W]] && !returning(bus.rd_addr_i[p*RA_W +: RA_W]))
            st = 1'b1;
      end
      return st;
   endfunction

   function automatic logic [XLEN-1:0] expCsr();
`ifdef FWD_CSR_EN
      if (w_csr_req_i && w_csr_addr_i == r_csr_addr_i) return w_csr_data_i;
`endif
      return r_csr_data_i;
   endfunction

   task automatic modelReset();
      foreach (mBusy[i]) mBusy[i] = 1'b0;
      mCnt  = 0;
      mScnt = 32'd0;
   endtask

   // Advance model across one clock edge using the inputs presented this cycle.
   task automatic modelAdvance();
      bit st, waw, full, doneAcc, issueAcc;
      st   = expStall();
      waw  = expWaw();
      full = (mCnt == MAX_LD);
      if (st && mScnt != 32'hFFFF_FFFF) mScnt = mScnt + 1;
      if (flush_i) begin
         foreach (mBusy[i]) mBusy[i] = 1'b0;
         mCnt = 0;
      end else begin
         doneAcc  = ld_done_i && mCnt > 0;
         issueAcc = ld_issue_i && !waw && (!full || doneAcc);
         if (doneAcc) mBusy[ld_done_rd_i] = 1'b0;
         if (issueAcc && ld_rd_i != 0) mBusy[ld_rd_i] = 1'b1;
         mCnt = mCnt + int'(issueAcc) - int'(doneAcc);
      end
   endtask

   task automatic checkOutput();
      for (int p = 0; p < NUM_RD; p++)
         checkVal($sformatf("rd_data_o[%0d]", p), bus.rd_data_o[p*XLEN +: XLEN], expOperand(p));
      checkVal("stall_o", 32'(stall_o), 32'(expStall()));
      checkVal("ld_full_o", 32'(ld_full_o), 32'(mCnt == MAX_LD));
      checkVal("stall_cnt_o", stall_cnt_o, mScnt);
      checkVal("r_csr_data_o", r_csr_data_o, expCsr());
   endtask

   // Called just after a falling edge with inputs set; checks, then crosses the rising edge.
   task automatic applyStimulus();
      #2;
      checkOutput();
      modelAdvance();
      @(negedge clk);
   endtask

   task automatic clearInputs();
      flush_i         = 1'b0;
      ld_issue_i      = 1'b0;
      ld_rd_i         = '0;
      ld_done_i       = 1'b0;
      ld_done_rd_i    = '0;
      bus.fwd_req_i   = '0;
      bus.fwd_addr_i  = '0;
      bus.fwd_data_i  = {$urandom, $urandom};
      bus.rd_use_i    = '0;
      bus.rd_addr_i   = '0;
      bus.rd_data_i   = {$urandom, $urandom};
      w_csr_req_i     = 1'b0;
      w_csr_addr_i    = '0;
      w_csr_data_i    = $urandom;
      r_csr_addr_i    = '0;
      r_csr_data_i    = $urandom;
   endtask

   initial begin
      clearInputs();
      modelReset();
      @(negedge clk);
      #2;
      checkOutput();
      checkVal("reset_stall_cnt", stall_cnt_o, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Priority forwarding: both sources write x5, youngest wins
      clearInputs();
      bus.fwd_req_i  = 2'b11;
      bus.fwd_addr_i = {5'd5, 5'd5};
      bus.fwd_data_i = {32'h0000_BBBB, 32'h0000_AAAA};
      bus.rd_addr_i  = {5'd0, 5'd5};
      bus.rd_data_i  = {32'h1111_2222, 32'h3333_4444};
      #1 checkVal("fwd_prio", bus.rd_data_o[31:0], 32'h0000_AAAA);
      checkVal("fwd_x0_port1", bus.rd_data_o[63:32], 32'h1111_2222);
      applyStimulus();

      // Writes to x0 are never forwarded
      clearInputs();
      bus.fwd_req_i  = 2'b11;
      bus.fwd_addr_i = {5'd0, 5'd0};
      bus.rd_addr_i  = {5'd0, 5'd0};
      applyStimulus();

      // Only the older source matches
      clearInputs();
      bus.fwd_req_i  = 2'b11;
      bus.fwd_addr_i = {5'd9, 5'd8};
      bus.fwd_data_i = {32'h0000_BBBB, 32'h0000_AAAA};
      bus.rd_addr_i  = {5'd9, 5'd8};
      #1 checkVal("fwd_old_src", bus.rd_data_o[63:32], 32'h0000_BBBB);
      applyStimulus();

      // Load-use on x7
      clearInputs(); ld_issue_i = 1'b1; ld_rd_i = 5'd7;
      applyStimulus();
      clearInputs(); bus.rd_use_i = 2'b10; bus.rd_addr_i = {5'd7, 5'd0};
      #1 checkVal("load_use_stall", 32'(stall_o), 32'd1);
      applyStimulus();
      clearInputs(); bus.rd_use_i = 2'b10; bus.rd_addr_i = {5'd7, 5'd0};
      ld_done_i = 1'b1; ld_done_rd_i = 5'd7;
      bus.fwd_req_i = 2'b01; bus.fwd_addr_i = {5'd0, 5'd7}; bus.fwd_data_i[31:0] = 32'hDEAD_BEEF;
      #1 checkVal("load_return_nostall", 32'(stall_o), 32'd0);
      checkVal("load_return_data", bus.rd_data_o[63:32], 32'hDEAD_BEEF);
      applyStimulus();
      clearInputs(); bus.rd_use_i = 2'b10; bus.rd_addr_i = {5'd7, 5'd0};
      #1 checkVal("busy_cleared", 32'(stall_o), 32'd0);
      applyStimulus();

      // Outstanding-load limit
      clearInputs(); ld_issue_i = 1'b1; ld_rd_i = 5'd3; applyStimulus();
      clearInputs(); ld_issue_i = 1'b1; ld_rd_i = 5'd4; applyStimulus();
      clearInputs(); ld_issue_i = 1'b1; ld_rd_i = 5'd6;
      #1 checkVal("full_flag", 32'(ld_full_o), 32'd1);
      checkVal("full_stall", 32'(stall_o), 32'd1);
      applyStimulus();
      clearInputs(); ld_issue_i = 1'b1; ld_rd_i = 5'd6; ld_done_i = 1'b1; ld_done_rd_i = 5'd3;
      applyStimulus();
      clearInputs();
      #1 checkVal("full_after_swap", 32'(ld_full_o), 32'd1);
      applyStimulus();
      clearInputs(); bus.rd_use_i = 2'b01; bus.rd_addr_i = {5'd0, 5'd6};
      applyStimulus();
      clearInputs(); flush_i = 1'b1; applyStimulus();

      // WAW on x9, flush in the stalled cycle
      clearInputs(); ld_issue_i = 1'b1; ld_rd_i = 5'd9; applyStimulus();
      clearInputs(); ld_issue_i = 1'b1; ld_rd_i = 5'd9;
      #1 checkVal("waw_stall", 32'(stall_o), 32'd1);
      applyStimulus();
      clearInputs(); ld_issue_i = 1'b1; ld_rd_i = 5'd9; flush_i = 1'b1;
      applyStimulus();
      clearInputs(); ld_issue_i = 1'b1; ld_rd_i = 5'd9;
      #1 checkVal("post_flush_nostall", 32'(stall_o), 32'd0);
      applyStimulus();
      clearInputs(); flush_i = 1'b1; applyStimulus();

      // Five stall cycles
      begin
         logic [31:0] base;
         base = mScnt;
         clearInputs(); ld_issue_i = 1'b1; ld_rd_i = 5'd2; applyStimulus();
         for (int i = 0; i < 5; i++) begin
            clearInputs(); bus.rd_use_i = 2'b01; bus.rd_addr_i = {5'd0, 5'd2};
            applyStimulus();
         end
         clearInputs();
         #1 checkVal("stall_cnt_plus5", stall_cnt_o, base + 32'd5);
         applyStimulus();
      end

      // Saturation from a preloaded count
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      #1 release dut.stall_cnt_q;
      mScnt = 32'hFFFF_FFFE;
      for (int i = 0; i < 3; i++) begin
         clearInputs(); bus.rd_use_i = 2'b01; bus.rd_addr_i = {5'd0, 5'd2};
         applyStimulus();
      end
      clearInputs();
      #1 checkVal("stall_cnt_sat", stall_cnt_o, 32'hFFFF_FFFF);
      applyStimulus();
      clearInputs(); flush_i = 1'b1; applyStimulus();

      // Async reset with a load outstanding
      clearInputs(); ld_issue_i = 1'b1; ld_rd_i = 5'd10; applyStimulus();
      clearInputs(); bus.rd_use_i = 2'b01; bus.rd_addr_i = {5'd0, 5'd10};
      #1 rst_n = 1'b0;
      #1 modelReset();
      checkOutput();
      checkVal("rst_mid_stall", 32'(stall_o), 32'd0);
      checkVal("rst_mid_cnt", stall_cnt_o, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      clearInputs(); ld_done_i = 1'b1; ld_done_rd_i = 5'd10; applyStimulus();
      clearInputs(); ld_issue_i = 1'b1; ld_rd_i = 5'd11; applyStimulus();
      clearInputs(); ld_issue_i = 1'b1; ld_rd_i = 5'd12; applyStimulus();
      clearInputs();
      #1 checkVal("late_done_ignored_full", 32'(ld_full_o), 32'd1);
      applyStimulus();
      clearInputs(); flush_i = 1'b1; applyStimulus();

      // CSR bypass
      clearInputs();
      w_csr_req_i = 1'b1; w_csr_addr_i = 12'h300; w_csr_data_i = 32'h0000_1234;
      r_csr_addr_i = 12'h300; r_csr_data_i = 32'h0000_5555;
`ifdef FWD_CSR_EN
      #1 checkVal("csr_bypass", r_csr_data_o, 32'h0000_1234);
`else
      #1 checkVal("csr_passthru", r_csr_data_o, 32'h0000_5555);
`endif
      applyStimulus();
      clearInputs();
      w_csr_req_i = 1'b1; w_csr_addr_i = 12'h301; r_csr_addr_i = 12'h300;
      applyStimulus();

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         clearInputs();
         bus.fwd_req_i  = NUM_SRC'($urandom);
         for (int s = 0; s < NUM_SRC; s++) bus.fwd_addr_i[s*RA_W +: RA_W] = RA_W'($urandom_range(0, 7));
         bus.rd_use_i   = NUM_RD'($urandom);
         for (int p = 0; p < NUM_RD; p++) bus.rd_addr_i[p*RA_W +: RA_W] = RA_W'($urandom_range(0, 7));
         ld_issue_i     = ($urandom_range(0, 2) == 0);
         ld_rd_i        = RA_W'($urandom_range(0, 7));
         ld_done_i      = ($urandom_range(0, 2) == 0);
         ld_done_rd_i   = RA_W'($urandom_range(0, 7));
         flush_i        = ($urandom_range(0, 30) == 0);
         w_csr_req_i    = 1'($urandom);
         w_csr_addr_i   = 12'h300 + 12'($urandom_range(0, 1));
         r_csr_addr_i   = 12'h300 + 12'($urandom_range(0, 1));
         applyStimulus();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
